// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit words with valid/ready on both sides,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dff_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CntW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] adv;
  logic             clear;

  assign clear = rst | flush;

  // Ready ripples from the output back to the input; a scalar carry avoids a self-looped vector.
  always_comb begin
    logic carry;
    carry = out_ready;
    adv   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      carry  = !v_q[i] || carry;
      adv[i] = carry;
    end
  end

  // Data registers only load on an incoming valid word so out_data stays put across bubbles.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (adv[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        d_d[0] = in_data;
      end
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (adv[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          d_d[i] = d_q[i-1];
        end
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CntW'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= RESET_VAL;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign in_ready  = adv[0] && !clear;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed checks on an 8x3 pipe, then random valid/ready against queue models on 1x1 and 32x8.
module tb_dff_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 8-bit, 3-deep instance for directed vectors
  logic       a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_count;

  // 1-bit, 1-deep instance
  logic       b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0] b_in_data, b_out_data;
  logic [0:0] b_count;

  // 32-bit, 8-deep instance
  logic        c_rst, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [3:0]  c_count;

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  dff_pipe #(.WIDTH(32), .DEPTH(8), .RESET_VAL(32'h0)) u_c (
    .clk(clk), .rst(c_rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .count(c_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] qb[$];
  logic [31:0] qc[$];
  logic [31:0] exp_w;
  logic [31:0] b_prev, c_prev;
  logic        b_stall, c_stall;
  int          seen;
  bit          drain;

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 8'hAA; a_out_ready = 1'b1;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    c_rst = 1'b1; c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;

    // Reset with a word offered
    cyc(); #1;
    check_eq("rst_outv", a_out_valid, 0);
    check_eq("rst_data", a_out_data, 8'h00);
    check_eq("rst_cnt", a_count, 0);
    check_eq("rst_rdy", a_in_ready, 0);
    cyc(); #1;
    check_eq("rst_rdy2", a_in_ready, 0);
    a_rst = 1'b0; a_in_valid = 1'b0;
    cyc(); #1;
    check_eq("post_rst_rdy", a_in_ready, 1);
    seen = 0;
    repeat (5) begin
      cyc(); #1;
      if (a_out_valid) seen++;
    end
    check_eq("rst_noword", seen, 0);

    // Streaming 01,02,03 with out_ready high
    a_in_valid = 1'b1; a_in_data = 8'h01; #1;
    check_eq("st_rdy", a_in_ready, 1);
    cyc(); a_in_data = 8'h02; #1;
    check_eq("st_cnt1", a_count, 1);
    check_eq("st_v1", a_out_valid, 0);
    cyc(); a_in_data = 8'h03; #1;
    check_eq("st_cnt2", a_count, 2);
    check_eq("st_v2", a_out_valid, 0);
    cyc(); a_in_valid = 1'b0; #1;
    check_eq("st_v3", a_out_valid, 1);
    check_eq("st_d3", a_out_data, 8'h01);
    check_eq("st_cnt3", a_count, 3);
    cyc(); #1;
    check_eq("st_d4", a_out_data, 8'h02);
    check_eq("st_cnt4", a_count, 2);
    cyc(); #1;
    check_eq("st_d5", a_out_data, 8'h03);
    check_eq("st_cnt5", a_count, 1);
    cyc(); #1;
    check_eq("st_v6", a_out_valid, 0);
    check_eq("st_cnt6", a_count, 0);

    // Back-pressure: three fill, fourth refused until a one-cycle release
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_in_data = 8'h10 + 8'(k); #1;
      check_eq("bp_rdy", a_in_ready, 1);
      cyc();
    end
    a_in_data = 8'h13; #1;
    check_eq("bp_full_rdy", a_in_ready, 0);
    check_eq("bp_full_cnt", a_count, 3);
    check_eq("bp_full_d", a_out_data, 8'h10);
    cyc(); #1;
    check_eq("bp_hold_d", a_out_data, 8'h10);
    check_eq("bp_hold_v", a_out_valid, 1);
    a_out_ready = 1'b1; #1;
    check_eq("bp_rel_rdy", a_in_ready, 1);
    cyc(); a_out_ready = 1'b0; a_in_valid = 1'b0; #1;
    check_eq("bp_swap_cnt", a_count, 3);
    check_eq("bp_swap_d", a_out_data, 8'h11);
    a_out_ready = 1'b1;
    cyc(); #1;
    check_eq("bp_dr_d12", a_out_data, 8'h12);
    cyc(); #1;
    check_eq("bp_dr_d13", a_out_data, 8'h13);
    check_eq("bp_dr_cnt", a_count, 1);
    cyc(); #1;
    check_eq("bp_dr_v", a_out_valid, 0);
    check_eq("bp_dr_cnt0", a_count, 0);

    // Bubble collapse under stall
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h20;
    cyc(); a_in_valid = 1'b0;
    cyc();
    cyc(); a_in_valid = 1'b1; a_in_data = 8'h21;
    cyc(); a_in_valid = 1'b0;
    cyc(); #1;
    check_eq("bub_cnt", a_count, 2);
    check_eq("bub_d", a_out_data, 8'h20);
    check_eq("bub_rdy", a_in_ready, 1);
    a_out_ready = 1'b1; #1;
    check_eq("bub_out0", a_out_data, 8'h20);
    cyc(); #1;
    check_eq("bub_v1", a_out_valid, 1);
    check_eq("bub_out1", a_out_data, 8'h21);
    cyc(); #1;
    check_eq("bub_v2", a_out_valid, 0);

    // Flush with two words held and 55 offered
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h30;
    cyc(); a_in_data = 8'h31;
    cyc(); a_in_data = 8'h55; a_flush = 1'b1; #1;
    check_eq("fl_pre_cnt", a_count, 2);
    check_eq("fl_rdy", a_in_ready, 0);
    cyc(); a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; #1;
    check_eq("fl_cnt", a_count, 0);
    check_eq("fl_v", a_out_valid, 0);
    check_eq("fl_d", a_out_data, 8'h00);
    seen = 0;
    repeat (6) begin
      cyc(); #1;
      if (a_out_valid) seen++;
    end
    check_eq("fl_noword", seen, 0);

    // Random valid/ready on the 1x1 and 32x8 instances, then drain
    b_rst = 1'b0; c_rst = 1'b0;
    b_stall = 1'b0; c_stall = 1'b0; b_prev = '0; c_prev = '0;
    drain = 1'b0;
    for (int n = 0; n < 620; n++) begin
      if (n == 600) drain = 1'b1;
      cyc();
      b_in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
      b_in_data   = 1'($urandom);
      b_out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      c_in_valid  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
      c_in_data   = $urandom;
      c_out_ready = drain ? 1'b1 : ($urandom_range(0, 2) == 0);
      #1;
      check_eq("b_count", 32'(b_count), qb.size());
      check_eq("b_rdy", b_in_ready, !(qb.size() == 1 && !b_out_ready));
      if (b_stall) begin
        check_eq("b_hold_v", b_out_valid, 1);
        check_eq("b_hold_d", 32'(b_out_data), b_prev);
      end
      if (b_out_valid && b_out_ready) begin
        check_eq("b_q_nonempty", qb.size() > 0, 1);
        if (qb.size() > 0) begin
          exp_w = qb.pop_front();
          check_eq("b_data", 32'(b_out_data), exp_w);
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back(32'(b_in_data));
      b_stall = b_out_valid && !b_out_ready;
      b_prev  = 32'(b_out_data);

      check_eq("c_count", 32'(c_count), qc.size());
      check_eq("c_rdy", c_in_ready, !(qc.size() == 8 && !c_out_ready));
      if (c_stall) begin
        check_eq("c_hold_v", c_out_valid, 1);
        check_eq("c_hold_d", c_out_data, c_prev);
      end
      if (c_out_valid && c_out_ready) begin
        check_eq("c_q_nonempty", qc.size() > 0, 1);
        if (qc.size() > 0) begin
          exp_w = qc.pop_front();
          check_eq("c_data", c_out_data, exp_w);
        end
      end
      if (c_in_valid && c_in_ready) qc.push_back(c_in_data);
      c_stall = c_out_valid && !c_out_ready;
      c_prev  = c_out_data;
    end
    check_eq("b_drained", qb.size(), 0);
    check_eq("c_drained", qc.size(), 0);
    check_eq("c_end_cnt", c_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit posedge D flip-flop: an elastic, multi-stage register pipeline of WIDTH-bit words with a valid/ready handshake on both sides.
- Supports per-stage bubble collapsing, a synchronous flush, and an occupancy count.
- Sits between producer and consumer blocks that need fixed registered latency, but must tolerate back-pressure without dropping or duplicating data.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- DEPTH, 3: number of register stages (>=1); unstalled latency in cycles.
- RESET_VAL, 0: value loaded into every stage data register on reset and flush.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of all stages; same effect as rst.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  WIDTH  input word.
- out_valid  output  1  stage DEPTH-1 holds a valid word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  stage DEPTH-1 data register.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- State per stage i (0..DEPTH-1): v[i] valid bit and d[i] WIDTH-bit data register. Stage 0 is nearest the input. out_valid=v[DEPTH-1] and out_data=d[DEPTH-1], both driven directly from registers.
- Reset: on posedge clk with rst=1, all v[i]=0 and all d[i]=RESET_VAL. As a result out_valid=0, out_data=RESET_VAL, count=0, and in_ready=1 combinationally from the next cycle onward.
- Flush: identical to rst. rst has priority, though both produce the same result. Any word offered or accepted in the flush cycle is discarded; the producer sees no accept that cycle.
- Advance rule, evaluated combinationally from the output back to the input:
  - adv[DEPTH] = out_ready.
  - adv[i] = !v[i] || adv[i+1].
  - Stage i loads when adv[i]=1. Stage 0 loads from in_data/in_valid; stage i>0 loads from stage i-1.
- Bubble collapsing: an empty stage always loads, even if downstream is stalled. Consequently DEPTH words can be held during a stall.
- Data registers load only when the incoming valid is 1. d[i] holds its value otherwise; only v[i] is cleared. This keeps out_data stable across bubbles.
- in_ready = adv[0], forced to 0 during rst or flush. The ready path is combinational from out_ready through all stages; this is intended and documented for timing.
- Handshake rules:
  - A transfer occurs when valid&&ready on either side.
  - out_data and out_valid must not change while out_valid=1 and out_ready=0.
  - in_valid may be deasserted freely; no word is lost if a transfer did not occur.
- Latency: with out_ready held at 1 and no bubbles, a word accepted at cycle N appears with out_valid=1 at cycle N+DEPTH. Throughput is 1 word/cycle.
- Simultaneous accept and emit when full: if all v=1 and out_ready=1, in_ready=1. The whole pipe shifts and count stays DEPTH.
- count: registered, equal to the popcount of v. Range 0..DEPTH, and it never exceeds DEPTH. It changes by at most ±1 per cycle except on rst/flush, where it goes to 0.
- Ordering: words leave in acceptance order; no duplication, no loss.
- X handling: in_data is ignored when in_valid=0. d[0] is not written in that case.

Test Plan:
- Reset state: assert rst for 2 cycles with in_valid=1, in_data=8'hAA → out_valid=0, out_data=RESET_VAL (8'h00), count=0, in_ready=0 during rst; no word appears later.
- Streaming, DEPTH=3: send 8'h01,8'h02,8'h03 on consecutive cycles with out_ready=1 → out_data 01,02,03 with out_valid=1 at cycles 3,4,5 after the first accept; count peaks at 3.
- Back-pressure and collapse: hold out_ready=0 and offer 8'h10,8'h11,8'h12,8'h13 → first three accepted, in_ready=0 on the 4th, count=3. Then pulse out_ready=1 for one cycle → 8'h10 emitted, 8'h13 accepted the same cycle, count stays 3.
- Bubble collapse: accept 8'h20, idle 2 cycles, accept 8'h21, with out_ready=0 → both packed into stages 2 and 1, count=2. On release → 20 then 21 on consecutive cycles.
- Flush mid-operation: with count=2, assert flush while in_valid=1, in_data=8'h55 → next cycle count=0, out_valid=0, out_data=8'h00; 8'h55 never emerges.
- Parameter sweep: WIDTH=1/DEPTH=1 and WIDTH=32/DEPTH=8 with random valid/ready → scoreboard matches in order; count equals the model occupancy every cycle; out_data stable while stalled.
